// File: rtl/fp_mul_round_stage.sv
// fp_mul_round_stage
//
// Final stage of the single-precision floating-point multiplier. It takes the
// raw 48-bit significand product, the biased exponent sum and the result sign.
// It normalises the product and rounds it to nearest-even. It then resolves the
// IEEE-754 special cases (NaN, infinity, zero) and exponent overflow/underflow.
// The stage is a two-entry elastic pipeline, and both sides use valid/ready
// handshakes.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready        upstream handshake
//   in_sign                    result sign
//   in_exp   [EXP_W-1:0]       signed exponent sum ex+ey-127
//   in_prod  [47:0]            unsigned {1.mx}*{1.my} product
//   in_zero, in_inf, in_nan    operand special-class indications
//   out_valid / out_ready      downstream handshake
//   out_result [31:0]          IEEE-754 single-precision result
//   out_flags  [3:0]           {invalid, overflow, underflow, inexact}
//
// Subnormal results are always flushed to signed zero. FLUSH_SUBNORMAL = 1 is
// the only supported setting.

module fp_mul_round_stage #(
   parameter int EXP_W           = 10,
   parameter bit FLUSH_SUBNORMAL = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [47:0]      in_prod,
   input  logic             in_zero,
   input  logic             in_inf,
   input  logic             in_nan,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [3:0]       out_flags
);

   // The exponent gets one extra bit. The +1 from normalisation and the +1
   // from a rounding carry therefore cannot wrap into the sign.
   localparam int E_W = EXP_W + 1;

   localparam logic signed [E_W-1:0] EXP_MAX  = E_W'(255);
   localparam logic signed [E_W-1:0] EXP_ZERO = '0;
   localparam logic [31:0]           QNAN     = 32'h7FC0_0000;

   // Stage 1: normalised significand and special class
   logic                  s1_valid_q,  s1_valid_d;
   logic                  s1_sign_q,   s1_sign_d;
   logic [22:0]           s1_mant_q,   s1_mant_d;
   logic                  s1_guard_q,  s1_guard_d;
   logic                  s1_sticky_q, s1_sticky_d;
   logic signed [E_W-1:0] s1_exp_q,    s1_exp_d;
   logic                  s1_zero_q,   s1_zero_d;
   logic                  s1_inf_q,    s1_inf_d;
   logic                  s1_nan_q,    s1_nan_d;
   logic                  s1_tiny_q,   s1_tiny_d;

   // Stage 2: packed result and flags
   logic                  s2_valid_q,  s2_valid_d;
   logic [31:0]           s2_result_q, s2_result_d;
   logic [3:0]            s2_flags_q,  s2_flags_d;

   logic                  in_fire;
   logic                  s1_adv;
   logic [46:0]           norm;

   logic                  round_up;
   logic [23:0]           mant_sum;
   logic signed [E_W-1:0] exp_r;
   logic [31:0]           res_c;
   logic [3:0]            flags_c;

   // Stage 1 may take a new entry in three cases: it is empty, it can drain
   // into an empty stage 2, or the whole pipe shifts because the output is
   // being consumed.
   assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
   assign in_fire  = in_valid && in_ready;
   assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);

   assign norm = in_prod[47] ? in_prod[46:0] : {in_prod[45:0], 1'b0};

   // ---------------- Stage 1 next state ----------------
   always_comb begin
      // NOTE: each _d starts at its held value. This gives every path an
      // assignment, so the block is purely combinational and infers no latch.
      s1_valid_d  = in_fire || (s1_valid_q && !s1_adv);
      s1_sign_d   = s1_sign_q;
      s1_mant_d   = s1_mant_q;
      s1_guard_d  = s1_guard_q;
      s1_sticky_d = s1_sticky_q;
      s1_exp_d    = s1_exp_q;
      s1_zero_d   = s1_zero_q;
      s1_inf_d    = s1_inf_q;
      s1_nan_d    = s1_nan_q;
      s1_tiny_d   = s1_tiny_q;
      if (in_fire) begin
         s1_sign_d   = in_sign;
         s1_mant_d   = norm[46:24];
         s1_guard_d  = norm[23];
         s1_sticky_d = |norm[22:0];
         s1_exp_d    = {in_exp[EXP_W-1], in_exp} + {{EXP_W{1'b0}}, in_prod[47]};
         s1_zero_d   = in_zero;
         s1_inf_d    = in_inf;
         s1_nan_d    = in_nan;
         // No leading one in the top two bits means the operands did not
         // describe a normal product. Such a product cannot be normalised
         // by one shift.
         s1_tiny_d   = (in_prod[47:46] == 2'b00);
      end
   end

   // ---------------- Stage 2 round / pack ----------------
   always_comb begin
      round_up = s1_guard_q && (s1_sticky_q || s1_mant_q[0]);
      mant_sum = {1'b0, s1_mant_q} + {23'b0, round_up};
      // A carry out of an all-ones mantissa leaves mant_sum[22:0] = 0. The
      // exponent then goes up by one.
      exp_r    = s1_exp_q + {{(E_W-1){1'b0}}, mant_sum[23]};

      res_c   = {s1_sign_q, exp_r[7:0], mant_sum[22:0]};
      flags_c = {3'b000, s1_guard_q || s1_sticky_q};

      if (s1_nan_q || (s1_inf_q && s1_zero_q)) begin
         res_c   = QNAN;
         flags_c = {s1_inf_q && s1_zero_q && !s1_nan_q, 3'b000};
      end else if (s1_inf_q) begin
         res_c   = {s1_sign_q, 8'hFF, 23'h0};
         flags_c = 4'b0000;
      end else if (s1_zero_q) begin
         res_c   = {s1_sign_q, 31'h0};
         flags_c = 4'b0000;
      end else if (s1_tiny_q) begin
         res_c   = {s1_sign_q, 31'h0};
         flags_c = 4'b0011;
      end else if (exp_r >= EXP_MAX) begin
         res_c   = {s1_sign_q, 8'hFF, 23'h0};
         flags_c = 4'b0101;
      end else if (FLUSH_SUBNORMAL && (exp_r <= EXP_ZERO)) begin
         res_c   = {s1_sign_q, 31'h0};
         flags_c = 4'b0011;
      end
   end

   always_comb begin
      s2_valid_d  = s1_adv || (s2_valid_q && !out_ready);
      s2_result_d = s2_result_q;
      s2_flags_d  = s2_flags_q;
      if (s1_adv) begin
         s2_result_d = res_c;
         s2_flags_d  = flags_c;
      end
   end

   // ---------------- State registers ----------------
   // NOTE: the datapath flops are reset along with the valids. The result
   // port therefore reads 0 after reset instead of stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_mant_q   <= '0;
         s1_guard_q  <= 1'b0;
         s1_sticky_q <= 1'b0;
         s1_exp_q    <= '0;
         s1_zero_q   <= 1'b0;
         s1_inf_q    <= 1'b0;
         s1_nan_q    <= 1'b0;
         s1_tiny_q   <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_flags_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the old
         // value of the others. Stage 2 can then take stage 1's contents in
         // the same edge that stage 1 reloads.
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_mant_q   <= s1_mant_d;
         s1_guard_q  <= s1_guard_d;
         s1_sticky_q <= s1_sticky_d;
         s1_exp_q    <= s1_exp_d;
         s1_zero_q   <= s1_zero_d;
         s1_inf_q    <= s1_inf_d;
         s1_nan_q    <= s1_nan_d;
         s1_tiny_q   <= s1_tiny_d;
         s2_valid_q  <= s2_valid_d;
         s2_result_q <= s2_result_d;
         s2_flags_q  <= s2_flags_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_result = s2_result_q;
   assign out_flags  = s2_flags_q;

endmodule

// File: tb/tb_fp_mul_round_stage.sv
// Self-checking bench for fp_mul_round_stage. Inputs change on the falling
// edge. Handshakes and outputs are sampled 1 time unit before the rising edge.
// Expected results come from a queue. Directed entries push hand-computed
// constants. Random entries push the output of an integer model of
// round-to-nearest-even.

module tb_fp_mul_round_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [47:0] in_prod;
   logic        in_zero;
   logic        in_inf;
   logic        in_nan;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_flags;

   int checks = 0;
   int errors = 0;

   logic [35:0] exp_q[$];
   logic [35:0] cur_exp;
   logic        stall_valid;
   logic [35:0] held;

   fp_mul_round_stage #(.EXP_W(10), .FLUSH_SUBNORMAL(1'b1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sign    (in_sign),
      .in_exp     (in_exp),
      .in_prod    (in_prod),
      .in_zero    (in_zero),
      .in_inf     (in_inf),
      .in_nan     (in_nan),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: the product is treated as an exact integer, and rounding
   // works on the integer remainder.
   function automatic logic [35:0] model(input logic s, input int e, input logic [47:0] p,
                                         input logic z, input logic i, input logic n);
      longint unsigned lp, sig, rem, half;
      int sh, ee;
      logic inexact;
      if (n || (i && z)) return {32'h7FC0_0000, (i && z && !n) ? 4'b1000 : 4'b0000};
      if (i) return {s, 8'hFF, 23'h0, 4'b0000};
      if (z) return {s, 31'h0, 4'b0000};
      if (p < 48'h4000_0000_0000) return {s, 31'h0, 4'b0011};
      lp   = 64'(p);
      sh   = p[47] ? 24 : 23;
      sig  = lp >> sh;
      rem  = lp & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      ee   = e + (sh - 23);
      inexact = (rem != 0);
      if (rem > half || (rem == half && sig[0])) sig = sig + 1;
      if (sig == (64'd1 << 24)) begin
         sig = sig >> 1;
         ee  = ee + 1;
      end
      if (ee >= 255) return {s, 8'hFF, 23'h0, 4'b0101};
      if (ee <= 0) return {s, 31'h0, 4'b0011};
      return {s, 8'(ee), sig[22:0], 3'b000, inexact};
   endfunction

   // Monitor: scoreboard pop, order check and stall-stability check.
   always @(negedge clk) begin
      #4;
      if (rst_n) begin
         if (out_valid) begin
            if (stall_valid) check("stable", {out_result, out_flags}, held);
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  check("spurious", 1, 0);
               end else begin
                  check("result", out_result, exp_q[0][35:4]);
                  check("flags", out_flags, exp_q[0][3:0]);
                  void'(exp_q.pop_front());
               end
            end
            stall_valid = !out_ready;
            held = {out_result, out_flags};
         end else begin
            stall_valid = 1'b0;
         end
         if (in_valid && in_ready) exp_q.push_back(cur_exp);
      end
   end

   // Called just after a falling edge. Returns just after the falling edge
   // that follows the accepting rising edge.
   task automatic send(input logic s, input int e, input logic [47:0] p,
                       input logic z, input logic i, input logic n, input logic [35:0] exp);
      logic acc;
      in_valid = 1'b1;
      in_sign  = s;
      in_exp   = 10'(e);
      in_prod  = p;
      in_zero  = z;
      in_inf   = i;
      in_nan   = n;
      cur_exp  = exp;
      for (int c = 0; c < 200; c++) begin
         #4;
         acc = in_ready;
         @(negedge clk);
         if (acc) break;
         if (c == 199) check("send_timeout", 1, 0);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      int bnd[9] = '{-1, 0, 1, 2, 126, 127, 253, 254, 255};
      logic acc;
      rst_n = 1'b0;
      in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_prod = '0;
      in_zero = 1'b0; in_inf = 1'b0; in_nan = 1'b0; out_ready = 1'b0;
      stall_valid = 1'b0; held = '0; cur_exp = '0;

      // Reset state
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_flags", out_flags, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rst_in_ready", in_ready, 1);
      @(negedge clk);

      // Directed cases with a free-running output; latency checked on the first
      out_ready = 1'b1;
      send(0, 128, 48'h6000_0000_0000, 0, 0, 0, {32'h4040_0000, 4'b0000});
      check("lat_not_yet", out_valid, 0);
      @(negedge clk);
      check("lat_two", out_valid, 1);
      send(0, 127, 48'h9000_0000_0000, 0, 0, 0, {32'h4010_0000, 4'b0000});
      send(0, 127, 48'h8000_0080_0000, 0, 0, 0, {32'h4000_0000, 4'b0001});
      send(0, 127, 48'h8000_0180_0000, 0, 0, 0, {32'h4000_0002, 4'b0001});
      send(0, 127, 48'hFFFF_FF80_0000, 0, 0, 0, {32'h4080_0000, 4'b0001});
      send(0, 254, 48'h8000_0000_0000, 0, 0, 0, {32'h7F80_0000, 4'b0101});
      send(1, 0,   48'h4000_0000_0000, 0, 0, 0, {32'h8000_0000, 4'b0011});
      send(0, 127, 48'h8000_0000_0000, 1, 1, 0, {32'h7FC0_0000, 4'b1000});
      send(1, 127, 48'h8000_0000_0000, 0, 1, 0, {32'hFF80_0000, 4'b0000});
      send(0, 127, 48'h8000_0000_0000, 0, 0, 1, {32'h7FC0_0000, 4'b0000});
      send(1, 127, 48'h8000_0000_0000, 1, 0, 0, {32'h8000_0000, 4'b0000});
      send(0, 127, 48'h1000_0000_0000, 0, 0, 0, {32'h0000_0000, 4'b0011});
      repeat (4) @(negedge clk);

      // Back-pressure: two accepts fill the pipe, the third needs out_ready
      out_ready = 1'b0;
      send(0, 130, 48'hA000_0000_0000, 0, 0, 0, model(0, 130, 48'hA000_0000_0000, 0, 0, 0));
      send(1, 100, 48'hC123_4567_89AB, 0, 0, 0, model(1, 100, 48'hC123_4567_89AB, 0, 0, 0));
      #1 check("bp_in_ready_low", in_ready, 0);
      repeat (2) @(negedge clk);
      out_ready = 1'b1;
      send(0, 5, 48'h7FFF_FFFF_FFFF, 0, 0, 0, model(0, 5, 48'h7FFF_FFFF_FFFF, 0, 0, 0));
      check("bp_no_gap_1", out_valid, 1);
      @(negedge clk);
      check("bp_no_gap_2", out_valid, 1);
      @(negedge clk);
      check("bp_drained", out_valid, 0);

      // Reset with both stages full
      out_ready = 1'b0;
      send(0, 127, 48'h8000_0000_0000, 0, 0, 0, {32'h4000_0000, 4'b0000});
      send(0, 128, 48'h8000_0000_0000, 0, 0, 0, {32'h4080_0000, 4'b0000});
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_result", out_result, 0);
      check("mid_rst_in_ready", in_ready, 1);
      exp_q.delete();
      stall_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #4 check("no_stale", out_valid, 0);
         @(negedge clk);
      end

      // Randomised traffic with random back-pressure
      acc = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         if (!in_valid || acc) begin
            if ($urandom_range(3) != 0) begin
               logic [63:0] r;
               logic [47:0] p;
               logic s, z, i, n;
               int e, kind;
               r = {$urandom, $urandom};
               p = r[47:0];
               s = r[63];
               z = 1'b0; i = 1'b0; n = 1'b0;
               kind = int'($urandom_range(19));
               if (p[47] == 1'b0) p[46] = 1'b1;
               case (kind)
                  0: z = 1'b1;
                  1: i = 1'b1;
                  2: n = 1'b1;
                  3: begin i = 1'b1; z = 1'b1; end
                  4: p = p & 48'h3FFF_FFFF_FFFF;
                  5: if (p[47]) begin p[23] = 1'b1; p[22:0] = '0; end
                     else begin p[22] = 1'b1; p[21:0] = '0; end
                  6: begin p[47] = 1'b1; p[46:23] = '1; end
                  default: ;
               endcase
               if ($urandom_range(3) == 0) e = bnd[$urandom_range(8)];
               else e = int'($urandom_range(507)) - 126;
               in_valid = 1'b1;
               in_sign  = s;
               in_exp   = 10'(e);
               in_prod  = p;
               in_zero  = z;
               in_inf   = i;
               in_nan   = n;
               cur_exp  = model(s, e, p, z, i, n);
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(3) != 0);
         #4 acc = in_valid && in_ready;
         @(negedge clk);
      end

      // Drain
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
      check("drain_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
